q_frag_bank: RTL and testbench



---
 rtl/q_frag_bank_if.sv | 39 +++
 rtl/q_frag_bank.sv | 79 +++++++
 tb/tb_q_frag_bank.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/q_frag_bank_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | q_frag_bank_if : control/data bundle of the q_frag_bank register |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface q_frag_bank_if #(
  parameter int WIDTH = 8
);
  logic             QEN;
  logic             CDS;
  logic [1:0]       QMODE;
  logic [WIDTH-1:0] QDI;
  logic             QSI;
  logic [WIDTH-1:0] QST;
  logic [WIDTH-1:0] UQST;
  logic             QSTS;
  logic [WIDTH-1:0] QRT;
  logic [WIDTH-1:0] UQRT;
  logic             QRTS;
  logic             NOTIFIER;
  logic             QVCLR;
  logic [WIDTH-1:0] AQZ;
  logic             QSO;
  logic             QCO;
  logic             VIOL;

  modport master (
    output QEN, CDS, QMODE, QDI, QSI, QST, UQST, QSTS, QRT, UQRT, QRTS,
           NOTIFIER, QVCLR,
    input  AQZ, QSO, QCO, VIOL
  );

  modport slave (
    input  QEN, CDS, QMODE, QDI, QSI, QST, UQST, QSTS, QRT, UQRT, QRTS,
           NOTIFIER, QVCLR,
    output AQZ, QSO, QCO, VIOL
  );
endinterface
`default_nettype wire

// File: rtl/q_frag_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | q_frag_bank : WIDTH-bit register with per-bit set/reset forcing, |
// | hold/load/shift/count modes, carry pulse and sticky violation.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module q_frag_bank #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  wire logic   QCK,
  input  wire logic   QRST,
  q_frag_bank_if.slave bus
);

  localparam logic [1:0]       c_MODE_LOAD  = 2'b01;
  localparam logic [1:0]       c_MODE_SHIFT = 2'b10;
  localparam logic [1:0]       c_MODE_COUNT = 2'b11;
  localparam logic [WIDTH-1:0] c_ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_aqz;
  logic             r_qco;
  logic             r_viol;
  logic             r_ntf_hist;

  logic [WIDTH-1:0] w_rt;
  logic [WIDTH-1:0] w_st;
  logic [WIDTH-1:0] w_mode;
  logic [WIDTH-1:0] w_next;
  logic             w_op;
  logic             w_carry;

  assign w_rt = bus.QRTS ? bus.UQRT : bus.QRT;
  assign w_st = bus.QSTS ? bus.UQST : bus.QST;
  assign w_op = bus.QEN && bus.CDS;

  always_comb begin
    w_mode = r_aqz;
    if (w_op) begin
      case (bus.QMODE)
        c_MODE_LOAD:  w_mode = bus.QDI;
        c_MODE_SHIFT: w_mode = {r_aqz[WIDTH-2:0], bus.QSI};
        c_MODE_COUNT: w_mode = r_aqz + c_ONE;
        default:      w_mode = r_aqz;
      endcase
    end
  end

  // Reset dominates set, set dominates the mode result, bit by bit.
  assign w_next  = (w_mode | w_st) & ~w_rt;
  assign w_carry = w_op && (bus.QMODE == c_MODE_COUNT) && (&r_aqz)
                   && !(|w_rt) && !(|w_st);

  always_ff @(posedge QCK) begin
    if (QRST) begin
      r_aqz      <= INIT;
      r_qco      <= 1'b0;
      r_viol     <= 1'b0;
      r_ntf_hist <= bus.NOTIFIER;
    end else begin
      r_aqz      <= w_next;
      r_qco      <= w_carry;
      r_ntf_hist <= bus.NOTIFIER;
      // A fresh detection wins over a clear in the same cycle.
      if (bus.NOTIFIER != r_ntf_hist) begin
        r_viol <= 1'b1;
      end else if (bus.QVCLR) begin
        r_viol <= 1'b0;
      end
    end
  end

  assign bus.AQZ  = r_aqz;
  assign bus.QSO  = r_aqz[WIDTH-1];
  assign bus.QCO  = r_qco;
  assign bus.VIOL = r_viol;

endmodule
`default_nettype wire

// File: tb/tb_q_frag_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_q_frag_bank : scoreboard bench for q_frag_bank (WIDTH=8).     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_q_frag_bank;

  localparam int         c_W    = 8;
  localparam logic [7:0] c_INIT = 8'hA5;

  typedef struct {
    int aqz;
    int qco;
    int viol;
  } exp_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  exp_t exp_q[$];

  int m_aqz;
  int m_qco;
  int m_viol;
  int m_hist;

  q_frag_bank_if #(.WIDTH(c_W)) bus ();

  q_frag_bank #(.WIDTH(c_W), .INIT(c_INIT)) dut (
    .QCK  (clk),
    .QRST (rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: next outputs derived from the behavioural rules.
  function automatic void predict();
    int   rt, st, m, nxt, op, mode;
    exp_t e;
    rt   = bus.QRTS ? int'(bus.UQRT) : int'(bus.QRT);
    st   = bus.QSTS ? int'(bus.UQST) : int'(bus.QST);
    op   = (bus.QEN && bus.CDS) ? 1 : 0;
    mode = int'(bus.QMODE);
    if (rst) begin
      m_aqz  = int'(c_INIT);
      m_qco  = 0;
      m_viol = 0;
      m_hist = int'(bus.NOTIFIER);
    end else begin
      if (op == 0 || mode == 0) m = m_aqz;
      else if (mode == 1)       m = int'(bus.QDI);
      else if (mode == 2)       m = (m_aqz * 2 + int'(bus.QSI)) % 256;
      else                      m = (m_aqz + 1) % 256;
      nxt = 0;
      for (int i = 0; i < c_W; i++) begin
        if ((rt >> i) & 1)      nxt = nxt;
        else if ((st >> i) & 1) nxt = nxt + (1 << i);
        else                    nxt = nxt + (((m >> i) & 1) << i);
      end
      m_qco = (op == 1 && mode == 3 && m_aqz == 255 && rt == 0 && st == 0) ? 1 : 0;
      if (int'(bus.NOTIFIER) != m_hist) m_viol = 1;
      else if (bus.QVCLR)               m_viol = 0;
      m_hist = int'(bus.NOTIFIER);
      m_aqz  = nxt;
    end
    e.aqz  = m_aqz;
    e.qco  = m_qco;
    e.viol = m_viol;
    exp_q.push_back(e);
  endfunction

  // Monitor: one registered result per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("AQZ",  int'(bus.AQZ),  e.aqz);
        chk("QCO",  int'(bus.QCO),  e.qco);
        chk("VIOL", int'(bus.VIOL), e.viol);
        chk("QSO",  int'(bus.QSO),  (e.aqz >> 7) & 1);
      end
    end
  end

  // Inputs change only after a falling edge; tick registers one cycle.
  task automatic tick();
    predict();
    @(posedge clk);
    #2;
  endtask

  task automatic next_drive();
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.QEN = 1'b0; bus.CDS = 1'b0; bus.QMODE = 2'b00; bus.QDI = '0;
    bus.QSI = 1'b0; bus.QST = '0; bus.UQST = '0; bus.QSTS = 1'b0;
    bus.QRT = '0; bus.UQRT = '0; bus.QRTS = 1'b0; bus.QVCLR = 1'b0;
  endtask

  task automatic op(input logic [1:0] mode, input logic [7:0] di, input logic si);
    next_drive();
    bus.QEN = 1'b1; bus.CDS = 1'b1; bus.QMODE = mode; bus.QDI = di; bus.QSI = si;
    tick();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    bus.NOTIFIER = 1'b0;
    quiet();

    // Reset with forces active and NOTIFIER toggling.
    next_drive();
    rst = 1'b1; bus.QST = 8'hFF; bus.QRT = 8'h0F; bus.QEN = 1'b1; bus.CDS = 1'b1;
    bus.QMODE = 2'b11; bus.NOTIFIER = 1'b1;
    tick();
    next_drive();
    bus.NOTIFIER = 1'b0;
    tick();
    chk("reset_AQZ", int'(bus.AQZ), 8'hA5);
    chk("reset_QCO", int'(bus.QCO), 0);
    next_drive();
    rst = 1'b0; quiet();
    tick();
    chk("post_reset_VIOL", int'(bus.VIOL), 0);
    chk("post_reset_AQZ", int'(bus.AQZ), 8'hA5);

    // Count through the wrap.
    op(2'b01, 8'hFE, 1'b0);
    op(2'b11, 8'h00, 1'b0);
    chk("cnt_FF", int'(bus.AQZ), 8'hFF);
    op(2'b11, 8'h00, 1'b0);
    chk("cnt_wrap", int'(bus.AQZ), 8'h00);
    chk("cnt_carry", int'(bus.QCO), 1);
    op(2'b11, 8'h00, 1'b0);
    chk("cnt_01", int'(bus.AQZ), 8'h01);
    chk("cnt_carry_off", int'(bus.QCO), 0);

    // Wrap with a set force suppresses the carry.
    op(2'b01, 8'hFE, 1'b0);
    op(2'b11, 8'h00, 1'b0);
    next_drive();
    bus.QST = 8'h01;
    tick();
    chk("forced_wrap", int'(bus.AQZ), 8'h01);
    chk("forced_no_carry", int'(bus.QCO), 0);
    next_drive();
    quiet();
    tick();

    // Load then shift.
    op(2'b01, 8'h3C, 1'b0);
    chk("load_3C", int'(bus.AQZ), 8'h3C);
    op(2'b10, 8'h00, 1'b1);
    chk("shift_79", int'(bus.AQZ), 8'h79);
    op(2'b10, 8'h00, 1'b1);
    chk("shift_F3", int'(bus.AQZ), 8'hF3);
    chk("qso_F3", int'(bus.QSO), 1);

    // Source-selected forcing, also with QEN low.
    next_drive();
    bus.QRTS = 1'b1; bus.UQRT = 8'h0F; bus.QRT = 8'hF0; bus.QSTS = 1'b0;
    bus.QST = 8'hFF; bus.UQST = 8'h00; bus.QEN = 1'b1; bus.CDS = 1'b1;
    bus.QMODE = 2'b01; bus.QDI = 8'h00;
    tick();
    chk("force_F0", int'(bus.AQZ), 8'hF0);
    next_drive();
    bus.QEN = 1'b0;
    tick();
    next_drive();
    quiet();

    // Violation flag.
    bus.NOTIFIER = ~bus.NOTIFIER;
    tick();
    chk("viol_set", int'(bus.VIOL), 1);
    next_drive();
    tick();
    next_drive();
    bus.NOTIFIER = ~bus.NOTIFIER; bus.QVCLR = 1'b1;
    tick();
    chk("viol_sticky", int'(bus.VIOL), 1);
    next_drive();
    tick();
    chk("viol_clr", int'(bus.VIOL), 0);
    next_drive();
    bus.QVCLR = 1'b0;
    tick();

    // CDS low blocks counting.
    next_drive();
    bus.QEN = 1'b1; bus.CDS = 1'b0; bus.QMODE = 2'b11;
    repeat (4) tick();

    // Reset mid-count.
    op(2'b01, 8'h05, 1'b0);
    op(2'b11, 8'h00, 1'b0);
    op(2'b11, 8'h00, 1'b0);
    chk("midcnt_07", int'(bus.AQZ), 8'h07);
    next_drive();
    rst = 1'b1;
    tick();
    chk("midcnt_reset", int'(bus.AQZ), 8'hA5);
    next_drive();
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 31) == 0);
      bus.QEN   = ($urandom_range(0, 7) != 0);
      bus.CDS   = ($urandom_range(0, 7) != 0);
      bus.QMODE = 2'($urandom_range(0, 3));
      bus.QDI   = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
      bus.QSI   = 1'($urandom);
      bus.QST   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      bus.UQST  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      bus.QRT   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      bus.UQRT  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      bus.QSTS  = 1'($urandom);
      bus.QRTS  = 1'($urandom);
      bus.QVCLR = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) bus.NOTIFIER = ~bus.NOTIFIER;
      tick();
      next_drive();
    end

    rst = 1'b0;
    quiet();
    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d results left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
